// File: rtl/rr_priority_arbiter_generic.sv
// rtl/rr_priority_arbiter_generic.sv - registered n-way round-robin / fixed-priority arbiter
//
// Registered arbiter with round-robin fairness, a runtime fixed-priority mode,
// grant locking and a bounded hold timer. It replaces the combinational
// priority encoder and keeps the same y/v meaning.
//
// Parameters:
//   n         number of requesters (2..32)
//   max_hold  max consecutive grant cycles while others wait; 0 = unlimited
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        request vector; bit k is held high by requester k until served
//   fixed_pri  1 = fixed priority (index n-1 highest), 0 = round-robin
//   grant      one-hot grant, registered
//   y          binary index of the granted requester, 0 when v=0
//   v          grant valid (equals |grant)

module rr_priority_arbiter_generic #(
  parameter int n        = 4,
  parameter int max_hold = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [n-1:0]         req,
  input  logic                 fixed_pri,
  output logic [n-1:0]         grant,
  output logic [$clog2(n)-1:0] y,
  output logic                 v
);

  localparam int yw = $clog2(n);
  localparam int cw = (max_hold > 0) ? $clog2(max_hold + 1) : 1;

  localparam logic [cw-1:0] cnt_max = cw'(max_hold);
  localparam logic [cw-1:0] cnt_one = cw'(1);
  localparam logic [yw-1:0] ptr_rst = yw'(n - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [yw-1:0]   ptr;
  logic [cw-1:0]   cnt;

  logic [n-1:0]    cand;
  logic            found;
  logic [yw-1:0]   win;
  logic [yw-1:0]   rr_idx;
  logic            holder_req;
  logic            hold_ok;

  // While a grant is active the current holder is excluded from the
  // candidates: a new winner is only needed on release or forced rotation.
  always_comb begin
    cand = req;
    if (state == GRANT) begin
      cand = req & ~grant;
    end
  end

  // Winner selection. Both loops overwrite on every hit so the preferred
  // candidate is the last one written: the highest index in fixed mode, and
  // the nearest index after ptr in round-robin mode (loop runs far-to-near).
  always_comb begin
    found  = 1'b0;
    win    = '0;
    rr_idx = '0;
    if (fixed_pri) begin
      for (int i = 0; i < n; i++) begin
        if (cand[i]) begin
          found = 1'b1;
          win   = yw'(i);
        end
      end
    end else begin
      for (int i = n; i >= 1; i--) begin
        rr_idx = yw'((int'(ptr) + i) % n);
        if (cand[rr_idx]) begin
          found = 1'b1;
          win   = rr_idx;
        end
      end
    end
  end

  // Holder still requesting, and still inside its hold budget.
  assign holder_req = |(req & grant);
  assign hold_ok    = (max_hold == 0) || (cnt < cnt_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      y     <= '0;
      v     <= 1'b0;
      ptr   <= ptr_rst;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            grant <= n'(1) << win;
            y     <= win;
            v     <= 1'b1;
            ptr   <= win;
            cnt   <= cnt_one;
          end
        end

        GRANT: begin
          if (!holder_req) begin
            // Release: hand over directly with no idle cycle when possible.
            if (found) begin
              grant <= n'(1) << win;
              y     <= win;
              ptr   <= win;
              cnt   <= cnt_one;
            end else begin
              state <= IDLE;
              grant <= '0;
              y     <= '0;
              v     <= 1'b0;
              cnt   <= '0;
            end
          end else if (hold_ok) begin
            // Locked grant; cnt only advances when a limit exists.
            if (max_hold != 0) begin
              cnt <= cnt + cnt_one;
            end
          end else if (found) begin
            // Hold budget spent and a competitor is waiting.
            grant <= n'(1) << win;
            y     <= win;
            ptr   <= win;
            cnt   <= cnt_one;
          end
          // Budget spent with no competitor: keep the grant and leave cnt at
          // max_hold so rotation fires as soon as a competitor shows up.
        end

        default: begin
          state <= IDLE;
          grant <= '0;
          y     <= '0;
          v     <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
